// File: rtl/rob_retire_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : rob_retire_ctrl
// Brief    : In-order retirement from the ROB head into the free list and the
//            architectural map, with a multi-cycle flush on mispredict.
// Revision : 1.0 - initial release
// =============================================================================
module rob_retire_ctrl #(
    parameter  int AREG_W       = 5,
    parameter  int PREG_W       = 6,
    parameter  int FLUSH_CYCLES = 2,
    parameter  int CNT_W        = 32,
    localparam int ROB_W        = 2 + 2*PREG_W + AREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROB_W-1:0]  robData_IN,
    input  logic              robEmpty_IN,
    input  logic              flFull_IN,
    input  logic              stall_IN,
    output logic              robPop_OUT,
    output logic              flPush_OUT,
    output logic [PREG_W-1:0] flData_OUT,
    output logic              commitValid_OUT,
    output logic [AREG_W-1:0] commitAreg_OUT,
    output logic [PREG_W-1:0] commitPreg_OUT,
    output logic              flush_OUT,
    output logic [CNT_W-1:0]  retiredCnt_OUT,
    output logic [CNT_W-1:0]  stallCnt_OUT
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] c_FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    logic [FC_W-1:0]   r_flushCnt;
    logic [CNT_W-1:0]  r_retiredCnt;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_done;
    logic w_mispredict;
    logic w_headDone;
    logic w_retire;
    logic w_fullStall;

    assign w_done       = robData_IN[0];
    assign w_mispredict = robData_IN[1];

    // Strobes are qualified by reset so nothing leaks out while reset is held.
    assign w_headDone  = reset && (r_state == RUN) && !robEmpty_IN && w_done && !stall_IN;
    assign w_retire    = w_headDone && !flFull_IN;
    assign w_fullStall = w_headDone && flFull_IN;

    assign robPop_OUT      = w_retire;
    assign flPush_OUT      = w_retire;
    assign commitValid_OUT = w_retire;
    assign flush_OUT       = reset && (r_state == FLUSH);

    assign flData_OUT     = robData_IN[2 +: PREG_W];
    assign commitPreg_OUT = robData_IN[2 + PREG_W +: PREG_W];
    assign commitAreg_OUT = robData_IN[2 + 2*PREG_W +: AREG_W];

    assign retiredCnt_OUT = r_retiredCnt;
    assign stallCnt_OUT   = r_stallCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= RUN;
            r_flushCnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_retire && w_mispredict) begin
                        r_state    <= FLUSH;
                        r_flushCnt <= c_FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (r_flushCnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_flushCnt <= r_flushCnt - FC_W'(1);
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_flushCnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retiredCnt <= '0;
            r_stallCnt   <= '0;
        end else begin
            if (w_retire) begin
                r_retiredCnt <= r_retiredCnt + CNT_W'(1);
            end
            if (w_fullStall) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_retire_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_rob_retire_ctrl
// Brief    : Self-checking bench for rob_retire_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_rob_retire_ctrl;

    localparam int AREG_W       = 5;
    localparam int PREG_W       = 6;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;
    localparam int ROB_W        = 2 + 2*PREG_W + AREG_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [ROB_W-1:0]  robData_IN;
    logic              robEmpty_IN;
    logic              flFull_IN;
    logic              stall_IN;
    logic              robPop_OUT;
    logic              flPush_OUT;
    logic [PREG_W-1:0] flData_OUT;
    logic              commitValid_OUT;
    logic [AREG_W-1:0] commitAreg_OUT;
    logic [PREG_W-1:0] commitPreg_OUT;
    logic              flush_OUT;
    logic [CNT_W-1:0]  retiredCnt_OUT;
    logic [CNT_W-1:0]  stallCnt_OUT;

    rob_retire_ctrl #(
        .AREG_W       (AREG_W),
        .PREG_W       (PREG_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .robData_IN      (robData_IN),
        .robEmpty_IN     (robEmpty_IN),
        .flFull_IN       (flFull_IN),
        .stall_IN        (stall_IN),
        .robPop_OUT      (robPop_OUT),
        .flPush_OUT      (flPush_OUT),
        .flData_OUT      (flData_OUT),
        .commitValid_OUT (commitValid_OUT),
        .commitAreg_OUT  (commitAreg_OUT),
        .commitPreg_OUT  (commitPreg_OUT),
        .flush_OUT       (flush_OUT),
        .retiredCnt_OUT  (retiredCnt_OUT),
        .stallCnt_OUT    (stallCnt_OUT)
    );

    always #5 clk = ~clk;

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    // Reference model: ROB contents, remaining flush cycles, event tallies.
    logic [ROB_W-1:0] q[$];
    int               mFlushLeft = 0;
    int unsigned      mRetired   = 0;
    int unsigned      mStall     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ROB_W-1:0] mkEntry(input int areg, input int newP,
                                                 input int oldP, input bit misp);
        logic [ROB_W-1:0] e;
        e = '0;
        e[1] = misp;
        e[2 +: PREG_W] = PREG_W'(oldP);
        e[2 + PREG_W +: PREG_W] = PREG_W'(newP);
        e[2 + 2*PREG_W +: AREG_W] = AREG_W'(areg);
        return e;
    endfunction

    // One clock: drive inputs, check at negedge, advance the model at posedge.
    task automatic step(input bit rstN, input bit doneF, input bit full, input bit stl);
        logic [ROB_W-1:0] head;
        bit empty, inFlush, expRet, expStallInc;
        empty   = (q.size() == 0);
        head    = empty ? ROB_W'($urandom) : q[0];
        head[0] = doneF;
        reset       = rstN;
        robData_IN  = head;
        robEmpty_IN = empty;
        flFull_IN   = full;
        stall_IN    = stl;
        inFlush     = (mFlushLeft > 0);
        expRet      = rstN && !inFlush && !empty && doneF && !full && !stl;
        expStallInc = rstN && !inFlush && !empty && doneF && full && !stl;
        @(negedge clk);
        chk("robPop",      64'(robPop_OUT),      64'(expRet));
        chk("flPush",      64'(flPush_OUT),      64'(expRet));
        chk("commitValid", 64'(commitValid_OUT), 64'(expRet));
        chk("flush",       64'(flush_OUT),       64'(rstN && inFlush));
        chk("flData",      64'(flData_OUT),      64'(head[2 +: PREG_W]));
        chk("commitPreg",  64'(commitPreg_OUT),  64'(head[2 + PREG_W +: PREG_W]));
        chk("commitAreg",  64'(commitAreg_OUT),  64'(head[2 + 2*PREG_W +: AREG_W]));
        chk("retiredCnt",  64'(retiredCnt_OUT),  64'(mRetired));
        chk("stallCnt",    64'(stallCnt_OUT),    64'(mStall));
        @(posedge clk);
        if (!rstN) begin
            mFlushLeft = 0;
            mRetired   = 0;
            mStall     = 0;
        end else begin
            if (inFlush) mFlushLeft--;
            if (expStallInc) mStall++;
            if (expRet) begin
                mRetired++;
                if (head[1]) mFlushLeft = FLUSH_CYCLES;
                void'(q.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0; robData_IN = '0; robEmpty_IN = 1'b1; flFull_IN = 1'b0; stall_IN = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then an empty ROB.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, i[0], 0, 0);
        chk("emptyRetired", 64'(retiredCnt_OUT), 64'd0);

        // Three back-to-back done entries.
        for (int i = 1; i <= 3; i++) q.push_back(mkEntry(i, 32 + i, i, 1'b0));
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        chk("retired3", 64'(retiredCnt_OUT), 64'd3);

        // Head not done for four cycles, then done.
        q.push_back(mkEntry(4, 36, 4, 1'b0));
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("notDoneStall", 64'(stallCnt_OUT), 64'd0);

        // Free list full for three cycles, external stall not counted.
        q.push_back(mkEntry(5, 37, 5, 1'b0));
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        chk("fullStall3", 64'(stallCnt_OUT), 64'd3);
        step(1, 1, 0, 0);
        chk("fullRetired", 64'(retiredCnt_OUT), 64'd5);

        // Mispredict on the second of three entries.
        step(0, 0, 0, 0);
        q.push_back(mkEntry(6, 40, 6, 1'b0));
        q.push_back(mkEntry(7, 41, 7, 1'b1));
        q.push_back(mkEntry(8, 42, 8, 1'b0));
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("mispRetired", 64'(retiredCnt_OUT), 64'd2);
        chk("mispLeft",    64'(q.size()), 64'd1);
        step(1, 1, 0, 0);

        // Reset in the first flush cycle, then retirement resumes.
        q.push_back(mkEntry(9, 43, 9, 1'b1));
        q.push_back(mkEntry(10, 44, 10, 1'b0));
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rstFlush", 64'(flush_OUT), 64'd0);
        step(1, 1, 0, 0);
        chk("rstResume", 64'(retiredCnt_OUT), 64'd1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 8 && $urandom_range(0, 99) < 45)
                q.push_back(mkEntry($urandom_range(0, 31), $urandom_range(0, 63),
                                    $urandom_range(0, 63), $urandom_range(0, 99) < 10));
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
